// File: rtl/sar_scan_sequencer.sv
// Round-robin multi-channel scan controller for a SAR ADC core; optional per-channel averaging under AVERAGE_EN.
// Latency: start pulse SETTLE_CYC+1 cycles after channel select; result valid the cycle after the ready rising edge.
// Backpressure: a pending result holds valid/data/channel stable and no further conversion starts until accepted.
module sar_scan_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 16,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64
`ifdef AVERAGE_EN
    ,
    parameter int AVG_LOG2    = 2
`endif
    ,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    output logic [CH_W-1:0]   mux_sel_o,
    output logic              sar_start_o,
    input  logic              sar_rdy_i,
    input  logic [WIDTH-1:0]  sar_data_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [WIDTH-1:0]  res_data_o,
    output logic [CH_W-1:0]   res_ch_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_CONV   = 3'd4;
    localparam logic [2:0] ST_OUTPUT = 3'd5;

    // One counter serves both the settle wait and the conversion timeout.
    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CH_W-1:0]  LAST_CH_RST = CH_W'(NUM_CH - 1);

`ifdef AVERAGE_EN
    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int SUB_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [SUB_W-1:0] sub;

    assign acc_sum = acc + ACC_W'(sar_data_i);
`endif

    logic [2:0]       state;
    logic [CH_W-1:0]  last_ch;
    logic [CNT_W-1:0] cnt;
    logic             rdy_q;
    logic             rdy_rise;
    logic [CH_W-1:0]  lo_ch;
    logic [CH_W-1:0]  hi_ch;
    logic             hi_found;
    logic [CH_W-1:0]  next_ch;

    assign rdy_rise = sar_rdy_i & ~rdy_q;

    // Lowest set bit above last_ch, falling back to the lowest set bit overall (wrap).
    always_comb begin
        lo_ch    = '0;
        hi_ch    = '0;
        hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask_i[i]) begin
                lo_ch = CH_W'(i);
                if (CH_W'(i) > last_ch) begin
                    hi_ch    = CH_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign next_ch = hi_found ? hi_ch : lo_ch;

    assign sar_start_o = (state == ST_START);
    assign res_valid_o = (state == ST_OUTPUT);
    assign busy_o      = (state != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            last_ch    <= LAST_CH_RST;
            cnt        <= '0;
            rdy_q      <= 1'b0;
            mux_sel_o  <= '0;
            res_data_o <= '0;
            res_ch_o   <= '0;
            err_o      <= 1'b0;
`ifdef AVERAGE_EN
            acc        <= '0;
            sub        <= '0;
`endif
        end else begin
            rdy_q <= sar_rdy_i;
            case (state)
                ST_IDLE: begin
                    if (en_i && (|ch_mask_i)) begin
                        state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (!(|ch_mask_i)) begin
                        state <= ST_IDLE;
                    end else begin
                        mux_sel_o <= next_ch;
                        last_ch   <= next_ch;
                        cnt       <= '0;
`ifdef AVERAGE_EN
                        acc       <= '0;
                        sub       <= '0;
`endif
                        state     <= (SETTLE_CYC == 0) ? ST_START : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_CONV;
                end
                ST_CONV: begin
                    if (rdy_rise) begin
`ifdef AVERAGE_EN
                        acc <= acc_sum;
                        if (sub == SUB_LAST) begin
                            res_data_o <= WIDTH'(acc_sum >> AVG_LOG2);
                            res_ch_o   <= mux_sel_o;
                            state      <= ST_OUTPUT;
                        end else begin
                            sub   <= sub + 1'b1;
                            state <= ST_START;
                        end
`else
                        res_data_o <= sar_data_i;
                        res_ch_o   <= mux_sel_o;
                        state      <= ST_OUTPUT;
`endif
                    end else if (cnt == TMO_LAST) begin
                        // Channel is dropped; the sticky flag is the only trace of it.
                        err_o <= 1'b1;
                        state <= en_i ? ST_SELECT : ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready_i) begin
                        state <= en_i ? ST_SELECT : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Directed bench for sar_scan_sequencer with a behavioural SAR core model (rdy 20 cycles after start).
module tb_sar_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  mask;
    logic [1:0]  mux_sel;
    logic        sar_start;
    logic        sar_rdy = 1'b0;
    logic [15:0] sar_data = 16'd0;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_ch;
    logic        busy;
    logic        err;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // SAR model state
    int          cd        = 0;
    logic [1:0]  conv_ch   = 2'd0;
    logic        block_ch1 = 1'b0;
    logic        avg_mode  = 1'b0;
    int          avg_k     = 0;
    logic [15:0] avg_seq [0:3] = '{16'd100, 16'd101, 16'd102, 16'd105};

    sar_scan_sequencer #(
        .NUM_CH      (4),
        .WIDTH       (16),
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (64)
`ifdef AVERAGE_EN
        ,
        .AVG_LOG2    (2)
`endif
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .ch_mask_i   (mask),
        .mux_sel_o   (mux_sel),
        .sar_start_o (sar_start),
        .sar_rdy_i   (sar_rdy),
        .sar_data_i  (sar_data),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_ch_o    (res_ch),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sar_start) begin
            sar_rdy = 1'b0;
            cd      = 20;
            conv_ch = mux_sel;
        end else if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0 && !(block_ch1 && conv_ch == 2'd1)) begin
                sar_rdy = 1'b1;
                if (avg_mode) begin
                    sar_data = avg_seq[avg_k];
                    avg_k    = (avg_k + 1) % 4;
                end else begin
                    sar_data = 16'(1000 * (int'(conv_ch) + 1));
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag, output int t);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sar_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        t = cyc;
        check({tag, " start seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_result(input string tag, input int ech, input int edata, output int t);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        t = cyc;
        check({tag, " valid seen"}, 32'(found), 32'd1);
        check({tag, " ch"}, 32'(res_ch), ech);
        check({tag, " data"}, 32'(res_data), edata);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mux_sel"}, 32'(mux_sel), 32'd0);
        check({tag, " start"}, 32'(sar_start), 32'd0);
        check({tag, " valid"}, 32'(res_valid), 32'd0);
        check({tag, " data"}, 32'(res_data), 32'd0);
        check({tag, " ch"}, 32'(res_ch), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int t0, ts, th, tr, n_bad_valid, n_bad_stable, n_start, n_busy;
        rst       = 1'b1;
        en        = 1'b0;
        mask      = 4'b0000;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);

        // Round-robin over mask 1011 with no backpressure
        mask      = 4'b1011;
        en        = 1'b1;
        res_ready = 1'b1;
        t0        = cyc;
        wait_start("t1 s0", ts);
        check("t1 s0 delay", ts - t0, 32'd6);
        check("t1 s0 mux", 32'(mux_sel), 32'd0);
        wait_result("t1 r0", 0, 1000, th);
        check("t1 conv latency", th - ts, 32'd21);
        @(negedge clk);
        wait_start("t1 s1", ts);
        check("t1 s1 delay", ts - th, 32'd6);
        wait_result("t1 r1", 1, 2000, th);
        @(negedge clk);
        wait_start("t1 s2", ts);
        check("t1 s2 delay", ts - th, 32'd6);
        wait_result("t1 r2", 3, 4000, th);
        @(negedge clk);
        wait_start("t1 s3", ts);
        check("t1 s3 delay", ts - th, 32'd6);
        wait_result("t1 r3", 0, 1000, th);
        @(negedge clk);

        // Backpressure: result held, no new start
        res_ready = 1'b0;
        wait_result("t2 r", 1, 2000, th);
        n_bad_valid  = 0;
        n_bad_stable = 0;
        n_start      = 0;
        repeat (50) begin
            @(negedge clk);
            if (res_valid !== 1'b1) n_bad_valid++;
            if (res_data !== 16'd2000 || res_ch !== 2'd1) n_bad_stable++;
            if (sar_start === 1'b1) n_start++;
        end
        check("t2 valid held", n_bad_valid, 32'd0);
        check("t2 data stable", n_bad_stable, 32'd0);
        check("t2 no start", n_start, 32'd0);
        res_ready = 1'b1;
        en        = 1'b0;
        @(negedge clk);
        check("t2 valid drop", 32'(res_valid), 32'd0);
        check("t2 idle", 32'(busy), 32'd0);

        // Empty mask keeps the block idle
        mask    = 4'b0000;
        en      = 1'b1;
        n_busy  = 0;
        n_start = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0) n_busy++;
            if (sar_start === 1'b1) n_start++;
        end
        check("t3 busy", n_busy, 32'd0);
        check("t3 no start", n_start, 32'd0);
        mask = 4'b0100;
        @(negedge clk);
        check("t3 busy after mask", 32'(busy), 32'd1);
        en = 1'b0;
        wait_result("t3 r", 2, 3000, th);
        @(negedge clk);
        check("t3 idle after", 32'(busy), 32'd0);

        // Timeout on channel 1
        mask      = 4'b0011;
        block_ch1 = 1'b1;
        en        = 1'b1;
        wait_result("t4 r0", 0, 1000, th);
        @(negedge clk);
        wait_start("t4 s1", ts);
        check("t4 s1 mux", 32'(mux_sel), 32'd1);
        repeat (64) @(negedge clk);
        check("t4 err before timeout", 32'(err), 32'd0);
        @(negedge clk);
        check("t4 err after timeout", 32'(err), 32'd1);
        wait_result("t4 r1", 0, 1000, tr);
        block_ch1 = 1'b0;
        @(negedge clk);

        // Reset mid-conversion on channel 2
        mask = 4'b0100;
        wait_start("t5 s", ts);
        check("t5 mux", 32'(mux_sel), 32'd2);
        repeat (5) @(negedge clk);
        check("t5 busy in conv", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5 reset");
        rst  = 1'b0;
        mask = 4'b0110;
        wait_start("t5 s after", ts);
        check("t5 mux after", 32'(mux_sel), 32'd1);
        wait_result("t5 r", 1, 2000, th);
        en = 1'b0;
        @(negedge clk);
        check("t5 idle", 32'(busy), 32'd0);

`ifdef AVERAGE_EN
        // Four back-to-back sub-conversions, single settle
        avg_mode = 1'b1;
        avg_k    = 0;
        mask     = 4'b0001;
        en       = 1'b1;
        t0       = cyc;
        wait_start("t6 s0", ts);
        check("t6 s0 delay", ts - t0, 32'd6);
        n_start = 1;
        tr      = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sar_start === 1'b1) n_start++;
            if (res_valid === 1'b1) begin
                tr = cyc;
                break;
            end
        end
        check("t6 starts", n_start, 32'd4);
        check("t6 span", tr - ts, 32'd84);
        check("t6 ch", 32'(res_ch), 32'd0);
        check("t6 data", 32'(res_data), 32'd102);
        en = 1'b0;
        @(negedge clk);
        avg_mode = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
